alu_exec: RTL
=============

Name: alu_exec

Overview:
Execute stage directly downstream of the datapath operand registers.
- Consumes Oprnd_A/Oprnd_B and a decoded ALU opcode.
- Produces the registered Op_Result and ALU_Zro/ALU_Neg/ALU_Carry, which the datapath writes back through RegPort_C and routes to its flag outputs.
- Single-cycle ops complete in one clock. MUL is an iterative 16-cycle shift-add with a busy/done handshake back to the controller.

Parameters:
WIDTH, 16, operand/result width (only 16 is verified)
MUL_CYCLES, 16, multiply iterations; must equal WIDTH

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
Start  in  1  one-cycle request; samples Alu_Op/operands
Alu_Op  in  4  operation code
Oprnd_A  in  16  operand A from datapath
Oprnd_B  in  16  operand B (register or immediate) from datapath
Carry_In  in  1  latched carry flag, used by ADDC/SUBB
Op_Result  out  16  registered result
ALU_Zro  out  1  result == 0
ALU_Neg  out  1  result[15]
ALU_Carry  out  1  carry/borrow/shift-out/overflow, per op
Busy  out  1  multiply in progress
Op_Done  out  1  one-cycle pulse when outputs are updated

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset, sampled on posedge clk.
- Reset values: Op_Result = 0x0000; ALU_Zro, ALU_Neg, ALU_Carry, Busy, Op_Done = 0. Internal state returns to IDLE.
- Opcodes:
  - 0 ADD: A+B. C = bit-16 carry-out.
  - 1 ADDC: A+B+Carry_In. C = carry-out.
  - 2 SUB: A-B. C = borrow (A<B unsigned).
  - 3 SUBB: A-B-Carry_In. C = borrow.
  - 4 AND, 5 OR, 6 XOR: bitwise. C = 0.
  - 7 NOT: ~A. C = 0.
  - 8 SHL: A << B[3:0]. C = last bit shifted out; 0 if amount is 0.
  - 9 SHR: logical right shift, same carry rule.
  - 10 ASR: arithmetic right shift, same carry rule.
  - 11 MUL: product[15:0]. C = |product[31:16].
  - 12 PASSB: B. C = 0.
  - 13-15: result 0x0000, C = 0.
- Z and N are always derived from the final 16-bit result. All arithmetic is unsigned 17-bit internally.
- Operands and Alu_Op are captured on the edge that samples Start. Upstream operands may change afterwards.
- State machine: IDLE, MUL_RUN, MUL_DONE.
  - IDLE, Start=1, non-MUL: result and flags registered on the same edge; Op_Done=1 for exactly the following cycle. Stay IDLE, so back-to-back Starts every cycle are legal.
  - IDLE, Start=1, MUL: load multiplicand, multiplier and a 32-bit accumulator = 0. Busy=1. Go to MUL_RUN with count = 0.
  - MUL_RUN: per edge, if multiplier LSB = 1, add the shifted multiplicand; shift; count++. After the 16th iteration, go to MUL_DONE.
  - MUL_DONE (one cycle): register result/flags, Op_Done=1, Busy=0, return to IDLE.
  - Net MUL timing: Op_Done is high 17 cycles after the Start edge; Busy is high for the 16 cycles before that.
- Start while Busy=1 is ignored: no capture, no queueing.
- Op_Result and flags hold their last values between operations.
- Reset in MUL_RUN aborts the multiply: all outputs go to reset values and no Op_Done is issued.
- Reset and Start in the same cycle: reset wins.

Optional Feature:
ALU_MUL_EN
- Defined: iterative multiplier and MUL_RUN/MUL_DONE states are built, as above.
- Undefined: multiplier logic and states are removed, Busy is tied to 0, and opcode 11 behaves as an undefined opcode (result 0x0000, Z=1, C=0, single-cycle Op_Done).

Test Plan:
1. ADD, A=0xFFFF, B=0x0001 -> next cycle Op_Result=0x0000, Z=1, N=0, C=1, Op_Done single pulse.
2. SUB, A=0x0003, B=0x0005 -> 0xFFFE, N=1, C=1, Z=0. Then SUBB with Carry_In=1, A=0x0010, B=0x0001 -> 0x000E, C=0.
3. SHL, A=0x8001, B=0x0001 -> 0x0002, C=1. ASR, A=0x8000, B=0x0004 -> 0xF800, N=1, C=0. SHL by 0 -> A unchanged, C=0.
4. MUL, A=0x0012, B=0x0034 -> Busy high 16 cycles, Op_Done 17 cycles after Start, 0x03A8, C=0. MUL, 0x0100 x 0x0100 -> 0x0000, Z=1, C=1.
5. Start ADD pulsed at cycle 5 of a MUL -> ignored; MUL result correct; exactly one Op_Done.
6. Assert reset at iteration 7 of a MUL -> next cycle all outputs 0, Busy=0, no Op_Done. A following ADD works normally. Repeat with ALU_MUL_EN undefined: MUL -> 0x0000, Z=1, Busy never asserted.

Source files
------------

// File: rtl/alu_exec_if.sv
// Controller/datapath <-> alu_exec bundle: request, operands and registered results.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [3:0]       Alu_Op;
  logic [WIDTH-1:0] Oprnd_A;
  logic [WIDTH-1:0] Oprnd_B;
  logic             Carry_In;
  logic [WIDTH-1:0] Op_Result;
  logic             ALU_Zro;
  logic             ALU_Neg;
  logic             ALU_Carry;
  logic             Busy;
  logic             Op_Done;

  modport master (
    output Start, Alu_Op, Oprnd_A, Oprnd_B, Carry_In,
    input  Op_Result, ALU_Zro, ALU_Neg, ALU_Carry, Busy, Op_Done
  );

  modport slave (
    input  Start, Alu_Op, Oprnd_A, Oprnd_B, Carry_In,
    output Op_Result, ALU_Zro, ALU_Neg, ALU_Carry, Busy, Op_Done
  );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 11 acts as an undefined opcode.
module alu_exec #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDC  = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SUBB  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_ASR   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd12;

  if (MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("alu_exec: MUL_CYCLES must equal WIDTH");
  end

  logic [WIDTH-1:0] result_q, result_d;
  logic             zro_q, zro_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  // alu_val packs {carry, result} for every single-cycle opcode.
  logic [WIDTH:0]   alu_val;
  logic [WIDTH:0]   a_ext, b_ext, cin_ext;
  logic [WIDTH:0]   sh_l, sh_r, sh_a;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    a_ext   = {1'b0, bus.Oprnd_A};
    b_ext   = {1'b0, bus.Oprnd_B};
    cin_ext = {{WIDTH{1'b0}}, bus.Carry_In};
    shamt   = bus.Oprnd_B[SH_W-1:0];
    // Right shifts carry a guard bit below the LSB so bit 0 is the last bit shifted out.
    sh_l    = a_ext << shamt;
    sh_r    = {bus.Oprnd_A, 1'b0} >> shamt;
    sh_a    = $signed({bus.Oprnd_A, 1'b0}) >>> shamt;
    alu_val = '0;
    case (bus.Alu_Op)
      OP_ADD:   alu_val = a_ext + b_ext;
      OP_ADDC:  alu_val = a_ext + b_ext + cin_ext;
      OP_SUB:   alu_val = a_ext - b_ext;
      OP_SUBB:  alu_val = a_ext - b_ext - cin_ext;
      OP_AND:   alu_val = {1'b0, bus.Oprnd_A & bus.Oprnd_B};
      OP_OR:    alu_val = {1'b0, bus.Oprnd_A | bus.Oprnd_B};
      OP_XOR:   alu_val = {1'b0, bus.Oprnd_A ^ bus.Oprnd_B};
      OP_NOT:   alu_val = {1'b0, ~bus.Oprnd_A};
      OP_SHL:   alu_val = sh_l;
      OP_SHR:   alu_val = {sh_r[0], sh_r[WIDTH:1]};
      OP_ASR:   alu_val = {sh_a[0], sh_a[WIDTH:1]};
      OP_PASSB: alu_val = b_ext;
      default:  alu_val = '0;
    endcase
  end

  logic             load;
  logic [WIDTH-1:0] new_res;
  logic             new_carry;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam int         CNT_W  = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    load      = 1'b0;
    new_res   = '0;
    new_carry = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Alu_Op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.Oprnd_A};
            mplier_d = bus.Oprnd_B;
            acc_d    = '0;
            count_d  = '0;
            state_d  = MUL_RUN;
          end else begin
            load      = 1'b1;
            new_res   = alu_val[WIDTH-1:0];
            new_carry = alu_val[WIDTH];
          end
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(MUL_CYCLES - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        load      = 1'b1;
        new_res   = acc_q[WIDTH-1:0];
        new_carry = |acc_q[2*WIDTH-1:WIDTH];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign bus.Busy = (state_q == MUL_RUN);
`else
  always_comb begin
    load      = bus.Start;
    new_res   = alu_val[WIDTH-1:0];
    new_carry = alu_val[WIDTH];
  end

  assign bus.Busy = 1'b0;
`endif

  // Result and flags only move on a completing operation; otherwise they hold.
  always_comb begin
    result_d = result_q;
    zro_d    = zro_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    if (load) begin
      result_d = new_res;
      zro_d    = (new_res == '0);
      neg_d    = new_res[WIDTH-1];
      carry_d  = new_carry;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zro_q    <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zro_q    <= zro_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign bus.Op_Result = result_q;
  assign bus.ALU_Zro   = zro_q;
  assign bus.ALU_Neg   = neg_q;
  assign bus.ALU_Carry = carry_q;
  assign bus.Op_Done   = done_q;
endmodule
